// File: rtl/ccg_harness_pkg.sv
// Shared types and constants for the characterisation harness:
// run-state encoding, default bus widths and the MISR step function.
package ccg_harness_pkg;

    localparam int DEF_RESP_W = 11;
    localparam int DEF_SIG_W = 16;
    localparam int MISR_MAX_W = 32;
    localparam logic [15:0] DEF_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // One MISR step on a w-bit register held in the low bits of a wide word.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] word,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] shifted;
        logic msb;
        mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - w);
        msb = |(sig & (MISR_MAX_W'(1) << (w - 1)));
        shifted = (sig << 1) & mask;
        if (msb) shifted = shifted ^ poly;
        return (shifted ^ word) & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// Signature register: loads SEED on a new run and folds in one
// response word per enabled cycle.
module ccg_misr
    import ccg_harness_pkg::*;
#(
    parameter int SIG_W = DEF_SIG_W,
    parameter int RESP_W = DEF_RESP_W,
    parameter logic [SIG_W-1:0] POLY = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] word,
    output logic [SIG_W-1:0]  sig,
    output logic [SIG_W-1:0]  sig_next
);

    assign sig_next = SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(word),
                                       MISR_MAX_W'(POLY), SIG_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/ccg_response_misr.sv
// Response compactor: run control, vector counter and golden compare
// around a single MISR instance.
module ccg_response_misr
    import ccg_harness_pkg::*;
#(
    parameter int RESP_W = DEF_RESP_W,
    parameter int SIG_W = DEF_SIG_W,
    parameter int CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [SIG_W-1:0]  golden,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count
);

    state_t state, state_nx;
    logic [CNT_W-1:0] num_q;
    logic [SIG_W-1:0] golden_q;
    logic [SIG_W-1:0] sig_next;
    logic start_ok;
    logic beat;
    logic last;

    assign start_ok = start && (state != ST_RUN);
    assign beat = (state == ST_RUN) && resp_valid;
    assign last = beat && ((vec_count + CNT_W'(1)) == num_q);

    assign resp_ready = (state == ST_RUN);
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = (num_vec == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            num_q <= '0;
            golden_q <= '0;
            vec_count <= '0;
            pass <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                num_q <= num_vec;
                golden_q <= golden;
                vec_count <= '0;
                pass <= (num_vec == '0) && (SEED == golden);
            end else if (beat) begin
                vec_count <= vec_count + CNT_W'(1);
                if (last) pass <= (sig_next == golden_q);
            end
        end
    end

    ccg_misr #(
        .SIG_W (SIG_W),
        .RESP_W(RESP_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .en      (beat),
        .word    (resp),
        .sig     (signature),
        .sig_next(sig_next)
    );

endmodule
